// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared widths, state encoding and data types for the line/burst adaptor
package mem_burst_pkg;
  localparam int LINE_W = 256;
  localparam int BURST_W = 64;
  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFFSET_BITS = 5;
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} burst_state_e;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BURST_W-1:0] beat_t;
endpackage

// File: rtl/line_beat_buffer.sv
// line_beat_buffer: line register with whole-line load, per-beat write and per-beat read mux
module line_beat_buffer #(
  parameter int LINE_W = 256,
  parameter int BURST_W = 64,
  parameter int BEATS = LINE_W / BURST_W,
  parameter int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [LINE_W-1:0]  i_line,
  input  logic               i_wr_beat,
  input  logic [CNT_W-1:0]   i_idx,
  input  logic [BURST_W-1:0] i_beat,
  output logic [LINE_W-1:0]  o_line,
  output logic [BURST_W-1:0] o_beat
);
  logic [LINE_W-1:0] r_line;
  // whole-line load for writes takes priority over beat assembly for reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_line <= '0;
    else if (i_load) r_line <= i_line;
    else if (i_wr_beat) r_line[i_idx*BURST_W +: BURST_W] <= i_beat;
  end
  assign o_line = r_line;
  assign o_beat = r_line[i_idx*BURST_W +: BURST_W];
endmodule

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: converts cacheline requests into multi-beat memory bursts and back
module line_burst_adaptor #(
  parameter int LINE_W = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  line_addr_i,
  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [LINE_W-1:0]  line_wdata_i,
  output logic [LINE_W-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [BURST_W-1:0] mem_wdata_o,
  input  logic [BURST_W-1:0] mem_rdata_i,
  input  logic               mem_resp_i
);
  import mem_burst_pkg::*;
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  if (LINE_W % BURST_W != 0) begin : g_bad_width
    $error("LINE_W must be an exact multiple of BURST_W");
  end
  burst_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic w_accept, w_load, w_wr_beat, w_last;
  logic [BURST_W-1:0] w_beat;
  assign w_last = r_cnt == CNT_W'(BEATS - 1);
  // next-state, beat counter and buffer controls
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    w_accept = 1'b0;
    w_load = 1'b0;
    w_wr_beat = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = line_read_i | line_write_i;
        w_load = !line_read_i && line_write_i;
        w_state_nxt = line_read_i ? RD_BURST : line_write_i ? WR_BURST : IDLE;
      end
      RD_BURST, WR_BURST: if (mem_resp_i) begin
        w_wr_beat = r_state == RD_BURST;
        w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
        w_state_nxt = w_last ? RESP : r_state;
      end
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // state, counter and line-aligned address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_accept) r_addr <= line_addr_i & ~ADDR_W'((1 << OFFSET_BITS) - 1);
    end
  end
  line_beat_buffer #(.LINE_W(LINE_W), .BURST_W(BURST_W)) u_buf (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_line(line_wdata_i),
    .i_wr_beat(w_wr_beat), .i_idx(r_cnt), .i_beat(mem_rdata_i),
    .o_line(line_rdata_o), .o_beat(w_beat)
  );
  assign mem_addr_o = r_addr;
  assign mem_read_o = r_state == RD_BURST;
  assign mem_write_o = r_state == WR_BURST;
  assign mem_wdata_o = mem_write_o ? w_beat : '0;
  assign line_resp_o = r_state == RESP;
  // the arbiter must never request a read and a write together; the read is served
  ap_one_request: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_state == IDLE && line_read_i && line_write_i))
    else $warning("simultaneous line read and write; read takes priority");
endmodule

// File: tb/tb_line_burst_adaptor.sv
// tb_line_burst_adaptor: directed table-driven and hand-sequenced checks of line_burst_adaptor
module tb_line_burst_adaptor;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] line_addr_i = '0, mem_addr_o;
  logic line_read_i = 1'b0, line_write_i = 1'b0, mem_resp_i = 1'b0;
  logic [255:0] line_wdata_i = '0, line_rdata_o;
  logic line_resp_o, mem_read_o, mem_write_o;
  logic [63:0] mem_wdata_o, mem_rdata_i = '0;
  int checks = 0, errors = 0;

  line_burst_adaptor dut (
    .clk(clk), .rst_n(rst_n), .line_addr_i(line_addr_i), .line_read_i(line_read_i),
    .line_write_i(line_write_i), .line_wdata_i(line_wdata_i), .line_rdata_o(line_rdata_o),
    .line_resp_o(line_resp_o), .mem_addr_o(mem_addr_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_resp_i(mem_resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr, mr;
    logic [63:0] mrd;
    logic [31:0] addr;
    logic er, ew, eresp;
    logic [63:0] ewd;
    logic [31:0] eaddr;
  } vec_t;
  vec_t q[$];

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111, B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333, B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] B5 = 64'h5555_5555_5555_5555, B6 = 64'h6666_6666_6666_6666;
  localparam logic [63:0] D0 = 64'hD0D0_0000_1111_00D0, D1 = 64'hD1D1_0000_2222_00D1;
  localparam logic [63:0] D2 = 64'hD2D2_0000_3333_00D2, D3 = 64'hD3D3_0000_4444_00D3;
  localparam logic [255:0] RLINE = {B4, B3, B2, B1};
  localparam logic [255:0] WLINE = {D3, D2, D1, D0};
  localparam logic [255:0] L2 = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_A5A5_5A5A_C3C3_3C3C_0F0F_F0F0_9696_6969;

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [255:0] l, input logic [31:0] ea, input logic both);
    line_read_i = 1'b1;
    line_write_i = both;
    line_addr_i = a;
    line_wdata_i = WLINE;
    mem_resp_i = 1'b0;
    tick();
    line_write_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_resp_i = 1'b0;
      line_addr_i = $urandom;
      tick();
      mem_resp_i = 1'b1;
      mem_rdata_i = l[k*64 +: 64];
      #1;
      chk("seq_mem_read", 256'(mem_read_o), 256'(1));
      chk("seq_mem_write", 256'(mem_write_o), 256'(0));
      chk("seq_mem_addr", 256'(mem_addr_o), 256'(ea));
      tick();
    end
    mem_resp_i = 1'b0;
    #1;
    chk("seq_resp", 256'(line_resp_o), 256'(1));
    chk("seq_line", line_rdata_o, l);
    line_read_i = 1'b0;
    tick();
    #1;
    chk("seq_resp_once", 256'(line_resp_o), 256'(0));
    chk("seq_line_hold", line_rdata_o, l);
  endtask

  initial begin
    q.push_back('{1, 0, 0, 64'h0, 32'h0000_1234, 0, 0, 0, 64'h0, 32'h0});
    q.push_back('{1, 0, 1, B1, 32'hAAAA_AAAA, 1, 0, 0, 64'h0, 32'h0000_1220});
    q.push_back('{1, 0, 1, B2, 32'h5555_5555, 1, 0, 0, 64'h0, 32'h0000_1220});
    q.push_back('{1, 0, 1, B3, 32'hFFFF_FFFF, 1, 0, 0, 64'h0, 32'h0000_1220});
    q.push_back('{1, 0, 1, B4, 32'h0000_0000, 1, 0, 0, 64'h0, 32'h0000_1220});
    q.push_back('{1, 0, 1, B5, 32'h0000_1234, 0, 0, 1, 64'h0, 32'h0000_1220});
    q.push_back('{0, 1, 1, B6, 32'h0000_2047, 0, 0, 0, 64'h0, 32'h0000_1220});
    q.push_back('{0, 1, 1, 64'h0, 32'hDEAD_BEEF, 0, 1, 0, D0, 32'h0000_2040});
    q.push_back('{0, 1, 0, 64'h0, 32'h1357_9BDF, 0, 1, 0, D1, 32'h0000_2040});
    q.push_back('{0, 1, 0, 64'h0, 32'h0000_0000, 0, 1, 0, D1, 32'h0000_2040});
    q.push_back('{0, 1, 1, 64'h0, 32'hFFFF_FFE0, 0, 1, 0, D1, 32'h0000_2040});
    q.push_back('{0, 1, 1, 64'h0, 32'h0000_2047, 0, 1, 0, D2, 32'h0000_2040});
    q.push_back('{0, 1, 0, 64'h0, 32'h0000_2047, 0, 1, 0, D3, 32'h0000_2040});
    q.push_back('{0, 1, 1, 64'h0, 32'h0000_2047, 0, 1, 0, D3, 32'h0000_2040});
    q.push_back('{0, 1, 0, 64'h0, 32'h0000_2047, 0, 0, 1, 64'h0, 32'h0000_2040});
    q.push_back('{0, 0, 0, 64'h0, 32'h0000_2047, 0, 0, 0, 64'h0, 32'h0000_2040});

    #12;
    chk("rst_mem_read", 256'(mem_read_o), 256'(0));
    chk("rst_mem_write", 256'(mem_write_o), 256'(0));
    chk("rst_resp", 256'(line_resp_o), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_wdata", 256'(mem_wdata_o), 256'(0));
    chk("rst_line", line_rdata_o, 256'(0));
    tick();
    rst_n = 1'b1;

    foreach (q[i]) begin
      line_read_i = q[i].rd;
      line_write_i = q[i].wr;
      mem_resp_i = q[i].mr;
      mem_rdata_i = q[i].mrd;
      line_addr_i = q[i].addr;
      line_wdata_i = (i == 6) ? WLINE : {8{$urandom}};
      #1;
      chk($sformatf("v%0d_mem_read", i), 256'(mem_read_o), 256'(q[i].er));
      chk($sformatf("v%0d_mem_write", i), 256'(mem_write_o), 256'(q[i].ew));
      chk($sformatf("v%0d_resp", i), 256'(line_resp_o), 256'(q[i].eresp));
      chk($sformatf("v%0d_wdata", i), 256'(mem_wdata_o), 256'(q[i].ewd));
      chk($sformatf("v%0d_mem_addr", i), 256'(mem_addr_o), 256'(q[i].eaddr));
      if (i == 6) chk("v6_read_line", line_rdata_o, RLINE);
      tick();
    end

    line_read_i = 1'b1;
    line_addr_i = 32'h0000_3FFF;
    tick();
    line_addr_i = 32'h0;
    mem_resp_i = 1'b1;
    mem_rdata_i = 64'h7777_7777_7777_7777;
    tick();
    mem_rdata_i = 64'h8888_8888_8888_8888;
    tick();
    mem_resp_i = 1'b0;
    #1;
    chk("mid_mem_read_before_rst", 256'(mem_read_o), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_read", 256'(mem_read_o), 256'(0));
    chk("mid_rst_resp", 256'(line_resp_o), 256'(0));
    chk("mid_rst_line", line_rdata_o, 256'(0));
    chk("mid_rst_addr", 256'(mem_addr_o), 256'(0));
    tick();
    rst_n = 1'b1;
    line_read_i = 1'b0;
    mem_resp_i = 1'b1;
    tick();
    #1;
    chk("post_rst_idle_read", 256'(mem_read_o), 256'(0));
    chk("post_rst_no_resp", 256'(line_resp_o), 256'(0));
    chk("post_rst_spurious_line", line_rdata_o, 256'(0));
    do_read(32'h0000_3FFF, L2, 32'h0000_3FE0, 1'b0);
    do_read(32'h8000_0047, RLINE, 32'h8000_0040, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
